screen_ctrl: RTL and testbench
==============================

Name: screen_ctrl

Overview:
- Top-level game-screen sequencer.
- Decides, once per frame, whether the VGA path shows the menu/result overlay or the live game.
- Selects which stored image the overlay ROM reader fetches by supplying a word base offset.
- Sits between the mouse/game-logic blocks and the overlay/background mux. Drives game enable and game reset, so screen changes never tear mid-frame.

Parameters:
- IMG_WORDS, 104796: words per stored screen image; image k starts at k*IMG_WORDS.
- DIGIT_FRAMES, 60: frames each countdown digit (3, 2, 1) is held.
- OVER_FRAMES, 300: frames the result screen is held before auto-return to menu.
- CNT_W, 9: frame counter width; must hold max(DIGIT_FRAMES, OVER_FRAMES)-1.

Ports:
- pclk  in  1  pixel clock; only clock
- rst  in  1  reset, asynchronous, active-low
- vblnk_in  in  1  vertical blank from VGA timing; rising edge = frame tick
- click_in  in  1  mouse left-button level, asynchronous to pclk
- game_over_in  in  1  one-cycle pulse from game logic: match finished
- winner_in  in  1  0 = player A won, 1 = player B won; valid with game_over_in
- screen_sel  out  2  0 = overlay only, 1 = game, 2 = game + result overlay
- overlay_en  out  1  overlay ROM reader enabled
- rom_base  out  20  word offset of the selected image
- game_run  out  1  physics/scoring enable
- game_reset  out  1  one-cycle pulse clearing game state
- cd_digit  out  2  countdown digit to display; 0 when not counting
- state_o  out  3  FSM state, for debug

Behaviour:
- Reset (rst low, async): state = MENU, frame_cnt = 0, all pending flags = 0.
- Output reset values: screen_sel = 0, overlay_en = 1, rom_base = 0, game_run = 0, game_reset = 0, cd_digit = 0.
- Frame tick: registered vblnk_d; frame_tick = vblnk_in & ~vblnk_d. Single cycle.
- Click path: 2-FF synchronizer plus rising-edge detect gives click_evt. click_pend is set by click_evt and cleared on frame_tick.
- Click arriving in the same cycle as frame_tick: set wins; the click is held for the next tick.
- Game-over path: over_pend and win_r are latched from game_over_in only while state == PLAY.
  - Same-cycle-as-tick rule is identical to the click path.
  - over_pend is cleared on leaving PLAY.
  - game_over_in in any other state is ignored.
- FSM: all transitions are evaluated only in frame_tick cycles. States MENU=0, CD=1, PLAY=2, OVER=3.
  - MENU: if click_pend, go to CD with frame_cnt = 0, digit = 3, and pulse game_reset (one cycle, registered).
  - CD: frame_cnt counts ticks. When frame_cnt == DIGIT_FRAMES-1: reset frame_cnt to 0 and decrement digit. When digit == 1 at that point, go to PLAY. Clicks are consumed and ignored.
  - PLAY: if over_pend, go to OVER with frame_cnt = 0, winner = win_r. Clicks are ignored.
  - OVER: if click_pend or frame_cnt == OVER_FRAMES-1, go to MENU. Otherwise frame_cnt counts. Click and timeout in the same tick give MENU once.
- frame_cnt never wraps; it is cleared on every state entry.
- Output decode (registered from next state, so visible the cycle after the tick):
  - MENU: screen_sel 0, overlay_en 1, rom_base 0, game_run 0.
  - CD: screen_sel 1, overlay_en 0, game_run 0, cd_digit = digit.
  - PLAY: screen_sel 1, overlay_en 0, game_run 1.
  - OVER: screen_sel 2, overlay_en 1, rom_base = IMG_WORDS (A won) or 2*IMG_WORDS (B won), game_run 0.
- Latency:
  - vblnk_in high sampled at edge T gives frame_tick in cycle T; new outputs are valid from edge T+1.
  - Click-to-pend latency: 3 cycles.
- Reset mid-operation returns to MENU immediately, regardless of blanking. The first frame after reset may tear; this is accepted.
- rom_base arithmetic: constants are computed at elaboration; 2*IMG_WORDS must be < 2^20. Use a static assertion.

Decomposition:
- Shared include file holds:
  - state encodings MENU/CD/PLAY/OVER;
  - screen_sel codes SCR_MENU/SCR_GAME/SCR_RESULT;
  - IMG_WORDS and the image index constants (IMG_TITLE = 0, IMG_WIN_A = 1, IMG_WIN_B = 2).
- One sub-module: sync_edge (2-FF synchronizer + rising-edge pulse, async active-low reset), used for click_in.
- The vblnk edge detector stays inline because vblnk_in is already pclk-synchronous.

Test Plan:
- Reset low mid-PLAY -> state_o = 0, overlay_en = 1, game_run = 0, rom_base = 0 asynchronously; these values hold after release.
- Click pulse in MENU, then a vblnk rise -> state CD, game_reset high exactly 1 cycle, cd_digit = 3. cd_digit = 2 after 60 ticks and 1 after 120; PLAY with game_run = 1 after 180 ticks.
- game_over_in with winner_in = 1 during PLAY -> at the next tick, state OVER, screen_sel = 2, rom_base = 209592. Auto-return to MENU after 300 ticks with no click.
- Click coincident with the frame_tick cycle in MENU -> no transition on that tick; transition to CD on the following tick.
- game_over_in pulsed during CD and MENU -> ignored; the first PLAY tick stays in PLAY.
- In OVER, click and timeout on the same tick -> single transition to MENU, no game_reset pulse; outputs change only on the cycle after the tick.

Source files
------------

// File: rtl/screen_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// screen_ctrl_pkg
// Shared definitions for the game-screen sequencer:
//   - FSM state encodings (MENU/CD/PLAY/OVER)
//   - screen_sel codes (SCR_MENU/SCR_GAME/SCR_RESULT)
//   - stored image geometry and image index constants
//   - img_base(): word offset of a stored image in the overlay ROM
// -----------------------------------------------------------------------------
package screen_ctrl_pkg;

   typedef enum logic [1:0] {
      MENU = 2'd0,
      CD   = 2'd1,
      PLAY = 2'd2,
      OVER = 2'd3
   } state_t;

   localparam logic [1:0] SCR_MENU   = 2'd0;
   localparam logic [1:0] SCR_GAME   = 2'd1;
   localparam logic [1:0] SCR_RESULT = 2'd2;

   localparam int ROM_AW    = 20;
   localparam int IMG_WORDS = 104796;

   localparam int IMG_TITLE = 0;
   localparam int IMG_WIN_A = 1;
   localparam int IMG_WIN_B = 2;

   // Image k starts at k*IMG_WORDS; only ever called with constants.
   function automatic logic [ROM_AW-1:0] img_base(input int idx);
      return ROM_AW'(idx * IMG_WORDS);
   endfunction

endpackage

// File: rtl/screen_ctrl_sync.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge
// detector producing a single-cycle pulse in the i_clk domain.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_async  asynchronous input level
//   o_rise   one-cycle pulse on each synchronized rising edge
// -----------------------------------------------------------------------------
module sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         r_sync_d <= 1'b0;
      end else begin
         r_meta   <= i_async;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/screen_ctrl.sv
// -----------------------------------------------------------------------------
// screen_ctrl
// Game-screen sequencer. Once per frame (rising edge of vblnk_in) decides
// whether the VGA path shows the menu/result overlay or the live game, which
// stored image the overlay ROM reader fetches, and drives game enable/reset.
// All screen changes happen on a frame tick, so nothing tears mid-frame.
// Ports:
//   pclk          pixel clock
//   rst           asynchronous active-low reset
//   vblnk_in      vertical blank (pclk-synchronous); rising edge = frame tick
//   click_in      mouse left button level, asynchronous
//   game_over_in  one-cycle pulse: match finished
//   winner_in     0 = player A, 1 = player B; valid with game_over_in
//   screen_sel    0 overlay only, 1 game, 2 game + result overlay
//   overlay_en    overlay ROM reader enable
//   rom_base      word offset of the selected image
//   game_run      physics/scoring enable
//   game_reset    one-cycle pulse clearing game state
//   cd_digit      countdown digit (3,2,1), 0 when not counting
//   state_o       FSM state for debug
// -----------------------------------------------------------------------------
module screen_ctrl
   import screen_ctrl_pkg::*;
#(
   parameter int DIGIT_FRAMES = 60,
   parameter int OVER_FRAMES  = 300,
   parameter int CNT_W        = 9
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              vblnk_in,
   input  logic              click_in,
   input  logic              game_over_in,
   input  logic              winner_in,
   output logic [1:0]        screen_sel,
   output logic              overlay_en,
   output logic [ROM_AW-1:0] rom_base,
   output logic              game_run,
   output logic              game_reset,
   output logic [1:0]        cd_digit,
   output logic [2:0]        state_o
);

   localparam logic [CNT_W-1:0]  DIG_LAST  = CNT_W'(DIGIT_FRAMES - 1);
   localparam logic [CNT_W-1:0]  OVER_LAST = CNT_W'(OVER_FRAMES - 1);
   localparam logic [ROM_AW-1:0] ROM_TITLE = img_base(IMG_TITLE);
   localparam logic [ROM_AW-1:0] ROM_WIN_A = img_base(IMG_WIN_A);
   localparam logic [ROM_AW-1:0] ROM_WIN_B = img_base(IMG_WIN_B);

   // Elaboration-time guards on constant ranges.
   if (IMG_WIN_B * IMG_WORDS >= (1 << ROM_AW)) begin : g_rom_range_chk
      $error("screen_ctrl: largest image base does not fit in rom_base");
   end
   if ((DIGIT_FRAMES - 1 >= (1 << CNT_W)) || (OVER_FRAMES - 1 >= (1 << CNT_W))) begin : g_cnt_range_chk
      $error("screen_ctrl: CNT_W too narrow for frame counts");
   end

   logic             r_vblnk_d;
   logic             w_frame_tick;
   logic             w_click_evt;
   logic             r_click_pend;
   logic             r_over_pend;
   logic             r_win;
   logic             w_leave_play;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       r_digit;
   logic [1:0]       w_digit_nxt;
   logic             r_winner;
   logic             w_winner_nxt;
   logic             w_greset_nxt;

   logic [1:0]        w_scr_nxt;
   logic              w_ovl_nxt;
   logic [ROM_AW-1:0] w_rom_nxt;
   logic              w_run_nxt;
   logic [1:0]        w_cd_nxt;

   // ---- frame tick and input event capture ----
   sync_edge u_click_sync (
      .i_clk   (pclk),
      .i_rst_n (rst),
      .i_async (click_in),
      .o_rise  (w_click_evt)
   );

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) r_vblnk_d <= 1'b0;
      else      r_vblnk_d <= vblnk_in;
   end

   assign w_frame_tick = vblnk_in & ~r_vblnk_d;
   assign w_leave_play = (r_state == PLAY) && (w_state_nxt != PLAY);

   // Pending flags: a new event beats the tick clear, so an event landing in
   // the tick cycle is carried to the next tick rather than lost.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_click_pend <= 1'b0;
         r_over_pend  <= 1'b0;
         r_win        <= 1'b0;
      end else begin
         if (w_click_evt)       r_click_pend <= 1'b1;
         else if (w_frame_tick) r_click_pend <= 1'b0;

         if (w_leave_play) begin
            r_over_pend <= 1'b0;
         end else if (game_over_in && (r_state == PLAY)) begin
            r_over_pend <= 1'b1;
            r_win       <= winner_in;
         end else if (w_frame_tick) begin
            r_over_pend <= 1'b0;
         end
      end
   end

   // ---- FSM: state register ----
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_state  <= MENU;
         r_cnt    <= '0;
         r_digit  <= 2'd0;
         r_winner <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_digit  <= w_digit_nxt;
         r_winner <= w_winner_nxt;
      end
   end

   // ---- FSM: next state, evaluated only on frame ticks ----
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_digit_nxt  = r_digit;
      w_winner_nxt = r_winner;
      w_greset_nxt = 1'b0;
      if (w_frame_tick) begin
         case (r_state)
            MENU: begin
               if (r_click_pend) begin
                  w_state_nxt  = CD;
                  w_cnt_nxt    = '0;
                  w_digit_nxt  = 2'd3;
                  w_greset_nxt = 1'b1;
               end
            end
            CD: begin
               if (r_cnt == DIG_LAST) begin
                  w_cnt_nxt = '0;
                  if (r_digit == 2'd1) begin
                     w_state_nxt = PLAY;
                     w_digit_nxt = 2'd0;
                  end else begin
                     w_digit_nxt = r_digit - 2'd1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            PLAY: begin
               if (r_over_pend) begin
                  w_state_nxt  = OVER;
                  w_cnt_nxt    = '0;
                  w_winner_nxt = r_win;
               end
            end
            OVER: begin
               // Click and timeout together still yield one return to MENU.
               if (r_click_pend || (r_cnt == OVER_LAST)) begin
                  w_state_nxt = MENU;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: w_state_nxt = MENU;
         endcase
      end
   end

   // ---- output decode from next state ----
   always_comb begin
      w_scr_nxt = SCR_MENU;
      w_ovl_nxt = 1'b1;
      w_rom_nxt = ROM_TITLE;
      w_run_nxt = 1'b0;
      w_cd_nxt  = 2'd0;
      case (w_state_nxt)
         MENU: ;
         CD: begin
            w_scr_nxt = SCR_GAME;
            w_ovl_nxt = 1'b0;
            w_cd_nxt  = w_digit_nxt;
         end
         PLAY: begin
            w_scr_nxt = SCR_GAME;
            w_ovl_nxt = 1'b0;
            w_run_nxt = 1'b1;
         end
         OVER: begin
            w_scr_nxt = SCR_RESULT;
            w_rom_nxt = w_winner_nxt ? ROM_WIN_B : ROM_WIN_A;
         end
         default: ;
      endcase
   end

   // ---- registered outputs, visible the cycle after the tick ----
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         screen_sel <= SCR_MENU;
         overlay_en <= 1'b1;
         rom_base   <= '0;
         game_run   <= 1'b0;
         game_reset <= 1'b0;
         cd_digit   <= 2'd0;
      end else begin
         screen_sel <= w_scr_nxt;
         overlay_en <= w_ovl_nxt;
         rom_base   <= w_rom_nxt;
         game_run   <= w_run_nxt;
         game_reset <= w_greset_nxt;
         cd_digit   <= w_cd_nxt;
      end
   end

   assign state_o = {1'b0, r_state};

endmodule

// File: tb/tb_screen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_screen_ctrl
// Self-checking bench for screen_ctrl: a frame-level reference model compared
// against every output on every falling clock edge, plus directed scenarios
// with literal expectations.
// -----------------------------------------------------------------------------
module tb_screen_ctrl;

   localparam int DIGIT_FRAMES = 60;
   localparam int OVER_FRAMES  = 300;
   localparam int WORDS        = 104796;

   logic        pclk;
   logic        rst;
   logic        vblnk_in;
   logic        click_in;
   logic        game_over_in;
   logic        winner_in;
   logic [1:0]  screen_sel;
   logic        overlay_en;
   logic [19:0] rom_base;
   logic        game_run;
   logic        game_reset;
   logic [1:0]  cd_digit;
   logic [2:0]  state_o;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 0;

   screen_ctrl #(
      .DIGIT_FRAMES (DIGIT_FRAMES),
      .OVER_FRAMES  (OVER_FRAMES),
      .CNT_W        (9)
   ) dut (
      .pclk         (pclk),
      .rst          (rst),
      .vblnk_in     (vblnk_in),
      .click_in     (click_in),
      .game_over_in (game_over_in),
      .winner_in    (winner_in),
      .screen_sel   (screen_sel),
      .overlay_en   (overlay_en),
      .rom_base     (rom_base),
      .game_run     (game_run),
      .game_reset   (game_reset),
      .cd_digit     (cd_digit),
      .state_o      (state_o)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Screen: 0 menu, 1 countdown, 2 play, 3 result. m_ticks = frame ticks
   // since entering the current screen; countdown digit is derived from it.
   int m_state, m_ticks, m_winner, m_win;
   bit m_click_p, m_over_p, m_grst;
   bit v_prev, h1, h2, h3;

   always @(posedge pclk or negedge rst) begin
      bit tick, evt;
      int old;
      if (!rst) begin
         m_state = 0; m_ticks = 0; m_winner = 0; m_win = 0;
         m_click_p = 0; m_over_p = 0; m_grst = 0;
         v_prev = 0; h1 = 0; h2 = 0; h3 = 0;
      end else begin
         tick   = vblnk_in && !v_prev;
         v_prev = vblnk_in;
         // a click sampled rising two edges ago becomes pending now
         evt = h2 && !h3;
         h3 = h2; h2 = h1; h1 = click_in;
         old    = m_state;
         m_grst = 0;
         if (tick) begin
            case (old)
               0: if (m_click_p) begin m_state = 1; m_ticks = 0; m_grst = 1; end
               1: begin
                  m_ticks++;
                  if (m_ticks == 3 * DIGIT_FRAMES) begin m_state = 2; m_ticks = 0; end
               end
               2: if (m_over_p) begin m_state = 3; m_ticks = 0; m_winner = m_win; end
               default: begin
                  m_ticks++;
                  if (m_click_p || m_ticks == OVER_FRAMES) begin m_state = 0; m_ticks = 0; end
               end
            endcase
         end
         if (evt) m_click_p = 1;
         else if (tick) m_click_p = 0;
         if (old == 2 && m_state != 2) m_over_p = 0;
         else if (game_over_in && old == 2) begin m_over_p = 1; m_win = winner_in; end
         else if (tick) m_over_p = 0;
      end
   end

   always @(negedge pclk) begin
      if (run_cmp) begin
         chk("m_state",      int'(state_o),    m_state);
         chk("m_screen_sel", int'(screen_sel), (m_state == 0) ? 0 : (m_state == 3) ? 2 : 1);
         chk("m_overlay_en", int'(overlay_en), (m_state == 0 || m_state == 3) ? 1 : 0);
         chk("m_rom_base",   int'(rom_base),   (m_state == 3) ? (m_winner + 1) * WORDS : 0);
         chk("m_game_run",   int'(game_run),   (m_state == 2) ? 1 : 0);
         chk("m_game_reset", int'(game_reset), int'(m_grst));
         chk("m_cd_digit",   int'(cd_digit),   (m_state == 1) ? 3 - m_ticks / DIGIT_FRAMES : 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Returns at the falling edge right after the tick edge (new outputs valid).
   task automatic tick();
      @(negedge pclk); vblnk_in = 1'b1;
      @(negedge pclk); vblnk_in = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic click();
      @(negedge pclk); click_in = 1'b1;
      @(negedge pclk);
      @(negedge pclk); click_in = 1'b0;
      repeat (4) @(negedge pclk);
   endtask

   task automatic pulse_over(input logic w);
      @(negedge pclk); game_over_in = 1'b1; winner_in = w;
      @(negedge pclk); game_over_in = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; vblnk_in = 1'b0; click_in = 1'b0;
      game_over_in = 1'b0; winner_in = 1'b0;
      repeat (3) @(negedge pclk);
      run_cmp = 1;
      chk("rst_state",   int'(state_o),    0);
      chk("rst_ovl",     int'(overlay_en), 1);
      chk("rst_rom",     int'(rom_base),   0);
      chk("rst_run",     int'(game_run),   0);
      chk("rst_greset",  int'(game_reset), 0);
      chk("rst_digit",   int'(cd_digit),   0);
      @(negedge pclk); rst = 1'b1;

      ticks(3);
      chk("menu_idle", int'(state_o), 0);
      pulse_over(1'b1);
      tick();
      chk("menu_over_ignored", int'(state_o), 0);

      // MENU -> countdown
      click();
      tick();
      chk("cd_entry_state",  int'(state_o),    1);
      chk("cd_entry_greset", int'(game_reset), 1);
      chk("cd_entry_digit",  int'(cd_digit),   3);
      chk("cd_entry_scr",    int'(screen_sel), 1);
      @(negedge pclk);
      chk("cd_greset_1cyc",  int'(game_reset), 0);
      pulse_over(1'b0);
      ticks(59);
      chk("cd_digit_59", int'(cd_digit), 3);
      tick();
      chk("cd_digit_60", int'(cd_digit), 2);
      ticks(60);
      chk("cd_digit_120", int'(cd_digit), 1);
      ticks(59);
      pulse_over(1'b1);
      chk("cd_179_state", int'(state_o), 1);
      tick();
      chk("play_state", int'(state_o),  2);
      chk("play_run",   int'(game_run), 1);
      chk("play_digit", int'(cd_digit), 0);
      tick();
      chk("play_holds", int'(state_o), 2);

      // PLAY -> result (B wins), auto return
      pulse_over(1'b1);
      tick();
      chk("over_state", int'(state_o),    3);
      chk("over_scr",   int'(screen_sel), 2);
      chk("over_rom_b", int'(rom_base),   209592);
      chk("over_ovl",   int'(overlay_en), 1);
      ticks(299);
      chk("over_299", int'(state_o), 3);
      tick();
      chk("over_timeout_menu", int'(state_o),  0);
      chk("over_timeout_rom",  int'(rom_base), 0);

      // click landing in the tick cycle is held for the next tick
      @(negedge pclk); click_in = 1'b1;
      @(negedge pclk);
      @(negedge pclk); vblnk_in = 1'b1;
      @(negedge pclk); vblnk_in = 1'b0; click_in = 1'b0;
      chk("coinc_no_move", int'(state_o), 0);
      tick();
      chk("coinc_next_cd", int'(state_o), 1);
      ticks(180);
      chk("play2_state", int'(state_o), 2);

      // A wins, then click and timeout on the same tick
      pulse_over(1'b0);
      tick();
      chk("over_rom_a", int'(rom_base), 104796);
      ticks(299);
      click();
      @(negedge pclk); vblnk_in = 1'b1;
      chk("both_pre_tick", int'(state_o), 3);
      @(negedge pclk); vblnk_in = 1'b0;
      chk("both_menu",   int'(state_o),    0);
      chk("both_greset", int'(game_reset), 0);
      ticks(2);
      chk("both_single", int'(state_o), 0);

      // asynchronous reset mid-PLAY
      click();
      tick();
      ticks(180);
      chk("play3_state", int'(state_o), 2);
      @(negedge pclk); #2 rst = 1'b0;
      #1;
      chk("arst_state", int'(state_o),    0);
      chk("arst_ovl",   int'(overlay_en), 1);
      chk("arst_run",   int'(game_run),   0);
      chk("arst_rom",   int'(rom_base),   0);
      chk("arst_scr",   int'(screen_sel), 0);
      repeat (3) @(negedge pclk);
      rst = 1'b1;
      ticks(3);
      chk("post_rst_state", int'(state_o),    0);
      chk("post_rst_ovl",   int'(overlay_en), 1);
      chk("post_rst_run",   int'(game_run),   0);

      run_cmp = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
